req_ack_sync_ctrl: RTL and testbench
====================================

# req_ack_sync_ctrl

Receive-side controller for multi-bit clock-domain crossings using a four-phase REQ/ACK handshake.
- A level request from a foreign domain passes through an internal NUM_STAGES synchronizer chain.
- The controller then captures the quasi-static data bus once and offers it to the local consumer with a VALID/READY handshake.
- After the consumer accepts, it returns ACK to the source domain.
- It sits at the destination edge of every bus crossing, beside the single-bit synchronizers.

## Interface
- NUM_STAGES, 3, synchronizer depth for REQ_ASYNC; legal range 2..4.
- BUS_WIDTH, 8, width of the crossed data bus.
- CNT_WIDTH, 8, width of the completed-transfer counter.

- CLK  in  1  destination-domain clock.
- RST  in  1  reset; synchronous, active-high.
- REQ_ASYNC  in  1  source-domain request level, asynchronous to CLK.
- DATA_ASYNC  in  BUS_WIDTH  source data; the source holds it stable while REQ_ASYNC is high.
- SYNC_READY  in  1  consumer accepts SYNC_BUS this cycle.
- SYNC_BUS  out  BUS_WIDTH  captured data (registered).
- SYNC_VALID  out  1  SYNC_BUS holds an unaccepted word (registered).
- ACK  out  1  acknowledge level to the source domain (registered; the source synchronizes it).
- PROTO_ERR  out  1  one-cycle pulse on a request protocol violation.
- XFER_CNT  out  CNT_WIDTH  number of completed transfers, modulo 2^CNT_WIDTH.

## Operation
- req_s is the output of a NUM_STAGES flop chain clocked by CLK with input REQ_ASYNC. All chain flops reset to 0.
- DATA_ASYNC is never synchronized bit-wise. It is sampled only at the single capture edge.
- FSM states and transitions:
  - IDLE: SYNC_VALID=0, ACK=0. If req_s=1, register DATA_ASYNC into SYNC_BUS and go to OFFER.
  - OFFER: SYNC_VALID=1. If SYNC_READY=1, increment XFER_CNT and go to ACK_HI. Otherwise stay.
  - ACK_HI: ACK=1. If req_s=0, go to IDLE. Otherwise stay.
- Protocol violation: req_s=0 while in OFFER means the source dropped REQ before ACK.
  - PROTO_ERR pulses for one cycle on the first such cycle only; there is no re-pulse while it stays low.
  - Data is already captured, so the offer continues. Completion proceeds normally to ACK_HI.
  - ACK_HI then sees req_s=0 and returns to IDLE after exactly one ACK cycle.
- Simultaneous events:
  - SYNC_READY=1 and req_s=0 in the same OFFER cycle: the transfer completes, XFER_CNT increments, and PROTO_ERR also pulses.
  - SYNC_READY while not in OFFER: ignored.
- SYNC_BUS holds its last captured value after the handshake until the next capture.
- XFER_CNT wraps from all-ones to 0 with no flag.
- Reset values: SYNC_BUS=0, SYNC_VALID=0, ACK=0, PROTO_ERR=0, XFER_CNT=0, state=IDLE.
- Reset mid-transfer: RST high at any CLK edge forces the reset values at that edge and discards the word in flight. A source still holding REQ high after reset restarts the transfer after NUM_STAGES+1 cycles.

## Timing
- Let REQ_ASYNC rise with setup met before edge E0. Then:
  - req_s=1 after edge E0+(NUM_STAGES-1).
  - Capture and SYNC_VALID=1 after edge E0+NUM_STAGES.
- SYNC_READY sampled high at edge E: after E, SYNC_VALID=0, ACK=1 and XFER_CNT is updated.
- REQ_ASYNC falls before edge F0: ACK=0 after edge F0+NUM_STAGES.
- Minimum full transaction with READY held high is 2*NUM_STAGES+2 cycles from the REQ rise to the ACK fall, excluding source-side ACK sync.
- Metastability settle time is the designer's concern only inside the sync chain. All other logic sees only req_s.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, OFFER=2'd1, ACK_HI=2'd2.
  - Legal-range constants for NUM_STAGES.
- One sub-module: sync_chain. It is a parameterized single-bit NUM_STAGES flop chain with synchronous active-high reset, instantiated once for REQ_ASYNC.
- The FSM, capture register and counter live in the top module.

## Test plan
- Basic transfer, NUM_STAGES=3:
  - Stimulus: DATA_ASYNC=8'hA5, REQ_ASYNC rises, SYNC_READY held 1.
  - Required: SYNC_VALID=1 with SYNC_BUS=8'hA5 at the 4th edge. ACK=1 one edge later. XFER_CNT=1. ACK falls 3 edges after the REQ fall. 0 rises to 1 ACK edges are checked.
- Consumer backpressure:
  - Stimulus: SYNC_READY held 0 for 10 cycles.
  - Required: SYNC_VALID and SYNC_BUS=8'hA5 stable, ACK=0 throughout. Asserting READY gives ACK=1 on the next edge.
- Early REQ drop:
  - Stimulus: REQ_ASYNC falls during OFFER.
  - Required: exactly one PROTO_ERR pulse. The word is still delivered. ACK high for exactly one cycle, then IDLE.
- Reset mid-transfer:
  - Stimulus: RST=1 for one edge during ACK_HI.
  - Required: all outputs are at reset values after that edge, with XFER_CNT=0. Because REQ is still high, a fresh capture occurs NUM_STAGES+1 edges after RST falls.
- Counter wrap, CNT_WIDTH=2:
  - Stimulus: 5 back-to-back transfers with data 1..5.
  - Required: XFER_CNT sequence 1,2,3,0,1, and SYNC_BUS matches each word.

Source files
------------

// File: rtl/req_ack_sync_ctrl_pkg.sv
// Purpose: shared types and constants for the req/ack CDC receive controller.
//   - state_t: FSM state encoding
//   - NUM_STAGES legal range and a helper that clamps a requested depth into it
package req_ack_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    ACK_HI = 2'd2
  } state_t;

  localparam int unsigned NUM_STAGES_MIN = 2;
  localparam int unsigned NUM_STAGES_MAX = 4;

  // Out-of-range synchronizer depths are clamped rather than producing a broken chain.
  function automatic int unsigned clamp_stages(input int unsigned n);
    if (n < NUM_STAGES_MIN) return NUM_STAGES_MIN;
    if (n > NUM_STAGES_MAX) return NUM_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/req_ack_sync_ctrl_sync_chain.sv
// Purpose: single-bit multi-flop synchronizer for an asynchronous level.
// Ports:
//   clk  in  destination clock
//   rst  in  synchronous active-high reset (all flops to 0)
//   d    in  asynchronous level
//   q    out synchronized level (last flop of the chain)
module sync_chain
  import req_ack_sync_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int unsigned DEPTH = clamp_stages(NUM_STAGES);

  logic [DEPTH-1:0] chain;

  // Shift register; only chain[0] may go metastable, later stages give it time to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/req_ack_sync_ctrl.sv
// Purpose: destination-side controller of a four-phase req/ack bus crossing.
//   Synchronizes the request, captures the quasi-static bus once, offers it with
//   valid/ready, then raises ack until the request is withdrawn.
// Ports:
//   clk         in  destination clock
//   rst         in  synchronous active-high reset
//   req_async   in  source request level (asynchronous)
//   data_async  in  source data, stable while req_async is high
//   sync_ready  in  consumer accepts sync_bus this cycle
//   sync_bus    out captured data word (registered)
//   sync_valid  out sync_bus holds an unaccepted word (registered)
//   ack         out acknowledge level back to the source (registered)
//   proto_err   out one-cycle pulse when the request drops before ack
//   xfer_cnt    out completed transfers, wraps silently
module req_ack_sync_ctrl
  import req_ack_sync_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_async,
  input  logic [BUS_WIDTH-1:0] data_async,
  input  logic                 sync_ready,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  output logic                 ack,
  output logic                 proto_err,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  state_t state;
  logic   req_s;
  logic   err_seen;  // early drop already reported during this offer

  sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (req_async),
    .q  (req_s)
  );

  // Handshake FSM with capture register, counter and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sync_bus   <= '0;
      sync_valid <= 1'b0;
      ack        <= 1'b0;
      proto_err  <= 1'b0;
      xfer_cnt   <= '0;
      err_seen   <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      case (state)
        IDLE: begin
          err_seen <= 1'b0;
          if (req_s) begin
            // Bus is quasi-static here: the source holds it while its request is high.
            sync_bus   <= data_async;
            sync_valid <= 1'b1;
            state      <= OFFER;
          end
        end

        OFFER: begin
          // Word is already captured, so an early drop is flagged but the offer continues.
          if (!req_s) begin
            proto_err <= !err_seen;
            err_seen  <= 1'b1;
          end
          if (sync_ready) begin
            sync_valid <= 1'b0;
            ack        <= 1'b1;
            xfer_cnt   <= xfer_cnt + CNT_WIDTH'(1);
            err_seen   <= 1'b0;
            state      <= ACK_HI;
          end
        end

        ACK_HI: begin
          if (!req_s) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          sync_valid <= 1'b0;
          ack        <= 1'b0;
          err_seen   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_ack_sync_ctrl.sv
// Purpose: directed self-checking bench for req_ack_sync_ctrl (NUM_STAGES=3,
//   BUS_WIDTH=8, CNT_WIDTH=2 so the counter wrap is reachable).
module tb_req_ack_sync_ctrl;

  localparam int unsigned NS = 3;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst;
  logic          req_async;
  logic [BW-1:0] data_async;
  logic          sync_ready;
  logic [BW-1:0] sync_bus;
  logic          sync_valid;
  logic          ack;
  logic          proto_err;
  logic [CW-1:0] xfer_cnt;

  int tests  = 0;
  int failed = 0;

  req_ack_sync_ctrl #(
    .NUM_STAGES(NS),
    .BUS_WIDTH (BW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_async (req_async),
    .data_async(data_async),
    .sync_ready(sync_ready),
    .sync_bus  (sync_bus),
    .sync_valid(sync_valid),
    .ack       (ack),
    .proto_err (proto_err),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_cnt;

    rst        = 1'b1;
    req_async  = 1'b0;
    data_async = '0;
    sync_ready = 1'b0;
    tick(2);

    // Reset state
    chk("rst_bus",   32'(sync_bus),   32'h0);
    chk("rst_valid", 32'(sync_valid), 32'h0);
    chk("rst_ack",   32'(ack),        32'h0);
    chk("rst_perr",  32'(proto_err),  32'h0);
    chk("rst_cnt",   32'(xfer_cnt),   32'h0);
    rst = 1'b0;
    tick(2);

    // Basic transfer: request rises before E0, capture after the 4th edge
    data_async = 8'hA5;
    req_async  = 1'b1;
    sync_ready = 1'b1;
    tick(3);
    chk("basic_valid_e2", 32'(sync_valid), 32'h0);
    tick(1);
    chk("basic_valid_e3", 32'(sync_valid), 32'h1);
    chk("basic_bus_e3",   32'(sync_bus),   32'hA5);
    chk("basic_ack_e3",   32'(ack),        32'h0);
    tick(1);
    chk("basic_ack_e4",   32'(ack),        32'h1);
    chk("basic_valid_e4", 32'(sync_valid), 32'h0);
    chk("basic_cnt_e4",   32'(xfer_cnt),   32'h1);
    req_async  = 1'b0;
    data_async = 8'h00;
    tick(3);
    chk("basic_ack_f2", 32'(ack), 32'h1);
    tick(1);
    chk("basic_ack_f3", 32'(ack),      32'h0);
    chk("basic_bus_hold", 32'(sync_bus), 32'hA5);
    tick(2);

    // Reset during ACK_HI with the request still high
    data_async = 8'h96;
    req_async  = 1'b1;
    tick(4);
    chk("rmt_valid", 32'(sync_valid), 32'h1);
    chk("rmt_bus",   32'(sync_bus),   32'h96);
    tick(1);
    chk("rmt_ack", 32'(ack),      32'h1);
    chk("rmt_cnt", 32'(xfer_cnt), 32'h2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rmt_rst_bus",   32'(sync_bus),   32'h0);
    chk("rmt_rst_valid", 32'(sync_valid), 32'h0);
    chk("rmt_rst_ack",   32'(ack),        32'h0);
    chk("rmt_rst_perr",  32'(proto_err),  32'h0);
    chk("rmt_rst_cnt",   32'(xfer_cnt),   32'h0);
    tick(3);
    chk("rmt_restart_early", 32'(sync_valid), 32'h0);
    tick(1);
    chk("rmt_restart_valid", 32'(sync_valid), 32'h1);
    chk("rmt_restart_bus",   32'(sync_bus),   32'h96);
    tick(1);
    chk("rmt_restart_ack", 32'(ack),      32'h1);
    chk("rmt_restart_cnt", 32'(xfer_cnt), 32'h1);
    req_async = 1'b0;
    tick(4);
    chk("rmt_ack_fall", 32'(ack), 32'h0);
    tick(2);

    // Consumer backpressure
    data_async = 8'hA5;
    sync_ready = 1'b0;
    req_async  = 1'b1;
    tick(4);
    chk("bp_valid_start", 32'(sync_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk($sformatf("bp_valid_%0d", i), 32'(sync_valid), 32'h1);
      chk($sformatf("bp_bus_%0d", i),   32'(sync_bus),   32'hA5);
      chk($sformatf("bp_ack_%0d", i),   32'(ack),        32'h0);
    end
    sync_ready = 1'b1;
    tick(1);
    chk("bp_ack",   32'(ack),        32'h1);
    chk("bp_valid", 32'(sync_valid), 32'h0);
    chk("bp_cnt",   32'(xfer_cnt),   32'h2);
    req_async = 1'b0;
    tick(4);
    chk("bp_ack_fall", 32'(ack), 32'h0);
    tick(2);

    // Early request drop during OFFER
    data_async = 8'h3C;
    sync_ready = 1'b0;
    req_async  = 1'b1;
    tick(4);
    chk("ed_valid", 32'(sync_valid), 32'h1);
    chk("ed_bus",   32'(sync_bus),   32'h3C);
    req_async = 1'b0;
    tick(3);
    chk("ed_perr_g2", 32'(proto_err), 32'h0);
    tick(1);
    chk("ed_perr_g3",  32'(proto_err),  32'h1);
    chk("ed_valid_g3", 32'(sync_valid), 32'h1);
    tick(1);
    chk("ed_perr_g4",  32'(proto_err),  32'h0);
    chk("ed_valid_g4", 32'(sync_valid), 32'h1);
    tick(1);
    chk("ed_perr_g5", 32'(proto_err), 32'h0);
    sync_ready = 1'b1;
    tick(1);
    chk("ed_ack",    32'(ack),        32'h1);
    chk("ed_valid",  32'(sync_valid), 32'h0);
    chk("ed_cnt",    32'(xfer_cnt),   32'h3);
    chk("ed_perr_c", 32'(proto_err),  32'h0);
    chk("ed_bus_c",  32'(sync_bus),   32'h3C);
    tick(1);
    chk("ed_ack_one_cycle", 32'(ack),        32'h0);
    chk("ed_idle_valid",    32'(sync_valid), 32'h0);
    tick(2);

    // Clear the counter before the wrap sequence
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("wrap_pre_cnt", 32'(xfer_cnt), 32'h0);

    // Counter wrap: five back-to-back transfers with data 1..5
    sync_ready = 1'b1;
    for (int d = 1; d <= 5; d++) begin
      data_async = 8'(d);
      req_async  = 1'b1;
      exp_cnt    = 2'(d % 4);
      tick(4);
      chk($sformatf("wrap_valid_%0d", d), 32'(sync_valid), 32'h1);
      chk($sformatf("wrap_bus_%0d", d),   32'(sync_bus),   32'(d));
      tick(1);
      chk($sformatf("wrap_ack_%0d", d), 32'(ack),      32'h1);
      chk($sformatf("wrap_cnt_%0d", d), 32'(xfer_cnt), 32'(exp_cnt));
      req_async = 1'b0;
      tick(4);
      chk($sformatf("wrap_ackfall_%0d", d), 32'(ack), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
